// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word length default and state encoding
package spi_pkg;

  localparam int SPI_DATALENGTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - 2-flop synchronizer with rise/fall pulses against a registered previous level
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // Pulses are valid in the cycle after the level reaches r_sync, so the
  // consuming logic acts on the third clock edge after the pin moved.
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled mode-0 SPI slave with TX holding register and RX pulse
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_DATALENGTH = SPI_DATALENGTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SPI_SCLK,
  input  logic                      SPI_CS_n,
  input  logic                      SPI_MOSI,
  output logic                      SPI_MISO,
  output logic                      SPI_MISO_oe,
  input  logic [SPI_DATALENGTH-1:0] txData,
  input  logic                      txValid,
  output logic                      txReady,
  output logic [SPI_DATALENGTH-1:0] recvData,
  output logic                      recvValid,
  output logic                      txUnderrun,
  output logic                      frameAbort
);

  localparam int CW = (SPI_DATALENGTH > 2) ? $clog2(SPI_DATALENGTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SPI_DATALENGTH - 1);

  spi_state_t r_state;
  spi_state_t w_state_next;

  logic                      r_mosi_meta;
  logic                      r_mosi_sync;
  logic [SPI_DATALENGTH-2:0] r_rx_shift;
  logic [SPI_DATALENGTH-1:0] r_tx_shift;
  logic [SPI_DATALENGTH-1:0] r_hold;
  logic                      r_hold_full;
  logic [CW-1:0]             r_bit_cnt;
  logic                      r_reload_pend;

  logic                      w_sclk_rise;
  logic                      w_sclk_fall;
  logic                      w_cs_rise;
  logic                      w_cs_fall;
  logic                      w_cs_edge;
  logic                      w_rise_v;
  logic                      w_fall_v;
  logic                      w_load;
  logic                      w_write;
  logic                      w_word_done;
  logic [SPI_DATALENGTH-1:0] w_rx_next;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .i_async (SPI_SCLK),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .i_async (SPI_CS_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= SPI_MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // A chip-select edge in the same cycle as a clock edge swallows the clock edge;
  // a master ending a frame drops SCLK and raises CS_n together to skip the reload.
  assign w_cs_edge   = w_cs_rise | w_cs_fall;
  assign w_rise_v    = (r_state == SHIFT) & ~w_cs_edge & w_sclk_rise;
  assign w_fall_v    = (r_state == SHIFT) & ~w_cs_edge & w_sclk_fall;
  assign w_load      = ((r_state == IDLE) & w_cs_fall) | (w_fall_v & r_reload_pend);
  assign w_write     = txValid & ~r_hold_full;
  assign w_word_done = w_rise_v & (r_bit_cnt == LAST_BIT);
  assign w_rx_next   = {r_rx_shift, r_mosi_sync};
  assign txReady     = ~r_hold_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    SPI_MISO_oe = 1'b0;
    SPI_MISO    = 1'b0;
    if (r_state == SHIFT) begin
      SPI_MISO_oe = 1'b1;
      SPI_MISO    = r_tx_shift[SPI_DATALENGTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_bit_cnt     <= '0;
      r_reload_pend <= 1'b0;
      recvData      <= '0;
      recvValid     <= 1'b0;
      txUnderrun    <= 1'b0;
      frameAbort    <= 1'b0;
    end else begin
      recvValid  <= 1'b0;
      txUnderrun <= 1'b0;
      frameAbort <= 1'b0;

      if ((r_state == IDLE) && w_cs_fall) begin
        r_bit_cnt <= '0;
      end

      if (w_rise_v) begin
        r_rx_shift <= w_rx_next[SPI_DATALENGTH-2:0];
        if (w_word_done) begin
          r_bit_cnt     <= '0;
          recvData      <= w_rx_next;
          recvValid     <= 1'b1;
          r_reload_pend <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_fall_v && r_reload_pend) begin
        r_reload_pend <= 1'b0;
      end

      if ((r_state == SHIFT) && w_cs_rise) begin
        r_reload_pend <= 1'b0;
        frameAbort    <= (r_bit_cnt != '0);
      end

      // Load priority: holding register, then same-cycle bypass, then all-ones underrun.
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift <= r_hold;
        end else if (w_write) begin
          r_tx_shift <= txData;
        end else begin
          r_tx_shift <= '1;
          txUnderrun <= 1'b1;
        end
      end else if (w_fall_v) begin
        r_tx_shift <= {r_tx_shift[SPI_DATALENGTH-2:0], 1'b1};
      end

      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_write && !w_load) begin
        r_hold      <= txData;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule
